// File: rtl/fp_phase_seq.sv
// fp_phase_seq: AWP floating/fixed-point phase sequencer feeding the F-PM unit.
// Accepts a started AWP instruction and steps one-hot through phases F1..F13.
// Each phase lasts PHASE_CYCLES clocks and carries strob_fp (k=1) and
// strob2_fp (k=last). Branches on F-PM status and reports busy/done/err.
//
// Ports:
//   __clk, rst_          clock, asynchronous active-low reset
//   start                instruction start request (level, sampled in IDLE)
//   af_sf, dw_df         instruction class: add/sub float, divide
//   fic, g, ws           F-PM status: iteration terminal, exp diff >= 40, correction
//   fi0..fi3             F-PM interrupt/error requests (abort while busy)
//   _0_f                 clear pulse to F-PM, high in the cycle start is accepted
//   f1..f13              one-hot phase outputs
//   strob_fp, strob2_fp  in-phase strobes
//   busy, done, err      sequence in progress, completion pulse, sticky abort flag
module fp_phase_seq #(
    parameter int unsigned PHASE_CYCLES = 3,
    parameter int unsigned LOOP_MAX     = 63
) (
    input  logic __clk,
    input  logic rst_,
    input  logic start,
    input  logic af_sf,
    input  logic dw_df,
    input  logic fic,
    input  logic g,
    input  logic ws,
    input  logic fi0,
    input  logic fi1,
    input  logic fi2,
    input  logic fi3,
    output logic _0_f,
    output logic f1,
    output logic f2,
    output logic f4,
    output logic f5,
    output logic f6,
    output logic f7,
    output logic f8,
    output logic f9,
    output logic f10,
    output logic f13,
    output logic strob_fp,
    output logic strob2_fp,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned KW  = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 2;
    localparam int unsigned LW  = (LOOP_MAX > 0) ? $clog2(LOOP_MAX + 1) : 1;
    localparam int unsigned NPH = 10;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_F1   = 4'd1;
    localparam logic [3:0] S_F2   = 4'd2;
    localparam logic [3:0] S_F4   = 4'd3;
    localparam logic [3:0] S_F5   = 4'd4;
    localparam logic [3:0] S_F6   = 4'd5;
    localparam logic [3:0] S_F7   = 4'd6;
    localparam logic [3:0] S_F8   = 4'd7;
    localparam logic [3:0] S_F9   = 4'd8;
    localparam logic [3:0] S_F10  = 4'd9;
    localparam logic [3:0] S_F13  = 4'd10;

    logic [3:0]     state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [LW-1:0]  loop_q, loop_d;
    logic           corr_q, corr_d;
    logic [NPH-1:0] phase_q, phase_d;
    logic           strob_q, strob_d;
    logic           strob2_q, strob2_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           accept_c;
    logic           fi_any_c;
    logic           k_last_c;
    logic           loop_hit_c;
    logic [LW-1:0]  loop_inc_c;

    // Phase output vector order: {f13, f10, f9, f8, f7, f6, f5, f4, f2, f1}
    function automatic logic [NPH-1:0] phase_onehot(input logic [3:0] s);
        logic [NPH-1:0] v;
        v = '0;
        case (s)
            S_F1:    v[0] = 1'b1;
            S_F2:    v[1] = 1'b1;
            S_F4:    v[2] = 1'b1;
            S_F5:    v[3] = 1'b1;
            S_F6:    v[4] = 1'b1;
            S_F7:    v[5] = 1'b1;
            S_F8:    v[6] = 1'b1;
            S_F9:    v[7] = 1'b1;
            S_F10:   v[8] = 1'b1;
            S_F13:   v[9] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign fi_any_c   = fi0 | fi1 | fi2 | fi3;
    assign k_last_c   = (k_q == KW'(PHASE_CYCLES - 1));
    // Abort when this F8 pass would bring the iteration count to LOOP_MAX
    assign loop_hit_c = ((32'(loop_q) + 32'd1) >= LOOP_MAX);
    assign loop_inc_c = (32'(loop_q) >= LOOP_MAX) ? loop_q : loop_q + LW'(1);

    // State and registered outputs
    always_ff @(posedge __clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            loop_q   <= '0;
            corr_q   <= 1'b0;
            phase_q  <= '0;
            strob_q  <= 1'b0;
            strob2_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            loop_q   <= loop_d;
            corr_q   <= corr_d;
            phase_q  <= phase_d;
            strob_q  <= strob_d;
            strob2_q <= strob2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next state, phase counter and next-cycle output values
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        loop_d   = loop_q;
        corr_d   = corr_q;
        err_d    = err_q;
        done_d   = 1'b0;
        accept_c = 1'b0;

        if (state_q == S_IDLE) begin
            // The done cycle is spent in IDLE; a held start is taken one clock later
            if (start && !done_q) begin
                accept_c = 1'b1;
                state_d  = S_F1;
                k_d      = '0;
                loop_d   = '0;
                corr_d   = 1'b0;
                err_d    = 1'b0;
            end
        end else if (fi_any_c) begin
            // F-PM abort outranks every phase transition
            state_d = S_IDLE;
            k_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
        end else if (!k_last_c) begin
            k_d = k_q + KW'(1);
        end else begin
            k_d = '0;
            case (state_q)
                S_F1:  state_d = S_F2;
                S_F2:  state_d = af_sf ? S_F5 : S_F4;
                S_F4:  state_d = S_F8;
                S_F5:  state_d = g ? S_F6 : S_F8;
                S_F8: begin
                    if (fic) begin
                        state_d = S_F6;
                    end else if (loop_hit_c) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        loop_d = loop_inc_c;
                    end
                end
                S_F6:  state_d = S_F7;
                S_F7:  state_d = S_F10;
                S_F10: begin
                    // Only one correction re-entry per instruction
                    if (ws && !corr_q) begin
                        state_d = S_F7;
                        corr_d  = 1'b1;
                    end else begin
                        state_d = dw_df ? S_F9 : S_F13;
                    end
                end
                S_F9:  state_d = S_F13;
                S_F13: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        phase_d  = phase_onehot(state_d);
        busy_d   = (state_d != S_IDLE);
        strob_d  = busy_d && (k_d == KW'(1));
        strob2_d = busy_d && (k_d == KW'(PHASE_CYCLES - 1));
    end

    assign _0_f      = accept_c & rst_;
    assign f1        = phase_q[0];
    assign f2        = phase_q[1];
    assign f4        = phase_q[2];
    assign f5        = phase_q[3];
    assign f6        = phase_q[4];
    assign f7        = phase_q[5];
    assign f8        = phase_q[6];
    assign f9        = phase_q[7];
    assign f10       = phase_q[8];
    assign f13       = phase_q[9];
    assign strob_fp  = strob_q;
    assign strob2_fp = strob2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
